// File: rtl/req_debounce_latch.sv
// Request front end for the 4-input priority encoder: synchronise, debounce and
// latch each clean rising edge as a sticky pending bit until the encoder retires it.
module req_debounce_latch #(
    parameter int NUM_REQ         = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_raw,
    input  logic               clr_valid,
    input  logic [1:0]         clr_idx,
    output logic [NUM_REQ-1:0] pending,
    output logic               any_pending,
    output logic [NUM_REQ-1:0] overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_REQ-1:0] s1;
    logic [NUM_REQ-1:0] s2;
    logic [NUM_REQ-1:0] deb;
    logic [NUM_REQ-1:0] accept;
    logic [NUM_REQ-1:0] rise;
    logic [NUM_REQ-1:0] clr_hit;
    logic [CNT_W-1:0]   cnt [NUM_REQ];

    // Retire handshake: clr_valid is a one-cycle strobe with no ready; the retire
    // named by clr_idx is always taken on the edge that samples clr_valid=1.
    always_comb begin
        accept  = '0;
        clr_hit = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            accept[i]  = (s2[i] != deb[i]) && (cnt[i] == CNT_MAX);
            clr_hit[i] = clr_valid && (int'(clr_idx) == i);
        end
        rise = accept & s2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            s2      <= '0;
            deb     <= '0;
            pending <= '0;
            overrun <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= req_raw;
            s2 <= s1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end

                // A new rise beats a same-cycle retire; overrun only flags a
                // rise landing on a line that stays pending without being served.
                if (rise[i]) begin
                    pending[i] <= 1'b1;
                    if (pending[i] && !clr_hit[i]) begin
                        overrun[i] <= 1'b1;
                    end
                end else if (clr_hit[i]) begin
                    pending[i] <= 1'b0;
                    overrun[i] <= 1'b0;
                end
            end
        end
    end

    assign any_pending = |pending;

endmodule

// File: tb/tb_req_debounce_latch.sv
// Directed bench for req_debounce_latch at DEBOUNCE_CYCLES=16: latency, glitch
// rejection, retire, set-wins-over-clear, overrun and mid-run reset.
module tb_req_debounce_latch;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_raw;
    logic       clr_valid;
    logic [1:0] clr_idx;
    logic [3:0] pending;
    logic       any_pending;
    logic [3:0] overrun;

    int checks = 0;
    int errors = 0;

    req_debounce_latch #(
        .NUM_REQ         (4),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_raw     (req_raw),
        .clr_valid   (clr_valid),
        .clr_idx     (clr_idx),
        .pending     (pending),
        .any_pending (any_pending),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit before sampling/driving.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic retire(input logic [1:0] idx);
        clr_valid = 1'b1;
        clr_idx   = idx;
        step(1);
        clr_valid = 1'b0;
        clr_idx   = 2'd0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_raw   = 4'b0000;
        clr_valid = 1'b0;
        clr_idx   = 2'd0;

        // Reset state
        step(2);
        check("reset_pending", pending, 4'b0000);
        check("reset_overrun", overrun, 4'b0000);
        check("reset_any", {3'b0, any_pending}, 4'b0000);

        // 1: line 0 rise latency, edge 17 still clear, edge 18 pending
        rst_n   = 1'b1;
        req_raw = 4'b0001;
        step(17);
        check("t1_pending_e17", pending, 4'b0000);
        check("t1_any_e17", {3'b0, any_pending}, 4'b0000);
        step(1);
        check("t1_pending_e18", pending, 4'b0001);
        check("t1_any_e18", {3'b0, any_pending}, 4'b0001);

        // 2: 10-cycle glitch on line 2 is discarded
        req_raw = 4'b0101;
        step(10);
        req_raw = 4'b0001;
        step(25);
        check("t2_pending", pending, 4'b0001);
        check("t2_overrun", overrun, 4'b0000);

        // 3: build pending=1010, then retire 3, a non-pending 0, then 1
        req_raw = 4'b0000;
        step(20);
        retire(2'd0);
        check("t3_clear0", pending, 4'b0000);
        req_raw = 4'b1010;
        step(18);
        check("t3_pending_1010", pending, 4'b1010);
        retire(2'd3);
        check("t3_clr3_pending", pending, 4'b0010);
        check("t3_clr3_any", {3'b0, any_pending}, 4'b0001);
        retire(2'd0);
        check("t3_clr_nonpending", pending, 4'b0010);
        retire(2'd1);
        check("t3_clr1_pending", pending, 4'b0000);
        check("t3_clr1_any", {3'b0, any_pending}, 4'b0000);

        // 4: line 0 pending, then a fresh rise accepted on the same edge as its retire
        req_raw = 4'b1011;
        step(18);
        check("t4_line0_pending", pending, 4'b0001);
        req_raw = 4'b1010;
        step(20);
        check("t4_fall_keeps_pending", pending, 4'b0001);
        req_raw = 4'b1011;
        step(17);
        retire(2'd0);
        check("t4_set_wins_pending", pending, 4'b0001);
        check("t4_set_wins_overrun", overrun, 4'b0000);

        // 5: line 1 made pending, then a second rise flags overrun; retire clears both
        req_raw = 4'b1001;
        step(20);
        req_raw = 4'b1011;
        step(20);
        check("t5_first_rise_pending", pending, 4'b0011);
        check("t5_first_rise_overrun", overrun, 4'b0000);
        req_raw = 4'b1001;
        step(20);
        req_raw = 4'b1011;
        step(20);
        check("t5_second_rise_pending", pending, 4'b0011);
        check("t5_overrun_set", overrun, 4'b0010);
        retire(2'd1);
        check("t5_retire_pending", pending, 4'b0001);
        check("t5_retire_overrun", overrun, 4'b0000);

        // 6: all lines high, async reset at edge 10, re-debounce from scratch
        req_raw = 4'b1111;
        step(10);
        rst_n = 1'b0;
        #1;
        check("t6_reset_pending", pending, 4'b0000);
        check("t6_reset_overrun", overrun, 4'b0000);
        check("t6_reset_any", {3'b0, any_pending}, 4'b0000);
        step(3);
        rst_n = 1'b1;
        step(17);
        check("t6_post_e17", pending, 4'b0000);
        step(1);
        check("t6_post_e18", pending, 4'b1111);
        check("t6_post_any", {3'b0, any_pending}, 4'b0001);
        check("t6_post_overrun", overrun, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
